// File: rtl/pb_debouncer.sv
// rtl/pb_debouncer.sv - debouncer for 6 push buttons and 16 slide switches
// Optional press-edge pulses are built when PB_DEBOUNCER_EDGE_EN is defined.
module pb_debouncer #(
    parameter int SIMULATE        = 0,
    parameter int TICK_DIV        = 100000,
    parameter int DB_TICKS        = 5,
    parameter int BTN0_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  pbtn_in,
    input  logic [15:0] switch_in,
    output logic [5:0]  pbtn_db,
    output logic [15:0] swtch_db,
    output logic [5:0]  pbtn_rise,
    output logic        tick
);

    localparam int TICK_DIV_E = (SIMULATE != 0) ? 4 : TICK_DIV;
    localparam int DB_TICKS_E = (SIMULATE != 0) ? 5 : DB_TICKS;
    localparam int PRE_W      = (TICK_DIV_E > 1) ? $clog2(TICK_DIV_E) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV_E - 1);
    localparam logic [3:0]       CNT_LAST = 4'(DB_TICKS_E - 1);
    localparam logic [21:0]      INV_MASK = (BTN0_ACTIVE_LOW != 0) ? 22'd1 : 22'd0;

    logic [21:0]      meta_q;
    logic [21:0]      sync_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick_q;
    logic [21:0]      db_q;
    logic [21:0]      db_d;
    logic [3:0]       cnt_q [22];
    logic [3:0]       cnt_d [22];

    // Button 0 is idle-high on the board; flipping it here keeps every debounced bit active-high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {switch_in, pbtn_in};
            sync_q <= meta_q ^ INV_MASK;
        end
    end

    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
    end

    // tick_q mirrors pre_q == PRE_LAST but comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_d == PRE_LAST);
        end
    end

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 22; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync_q[i] == db_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (tick_q) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i]  = sync_q[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_q <= '0;
            for (int i = 0; i < 22; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            db_q <= db_d;
            for (int i = 0; i < 22; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef PB_DEBOUNCER_EDGE_EN
    logic [5:0] db_prev_q;
    logic [5:0] rise_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_prev_q <= '0;
            rise_q    <= '0;
        end else begin
            db_prev_q <= db_q[5:0];
            rise_q    <= db_q[5:0] & ~db_prev_q;
        end
    end

    assign pbtn_rise = rise_q;
`else
    assign pbtn_rise = 6'b0;
`endif

    assign pbtn_db  = db_q[5:0];
    assign swtch_db = db_q[21:6];
    assign tick     = tick_q;

endmodule

// File: tb/tb_pb_debouncer.sv
// tb/tb_pb_debouncer.sv - directed scoreboard bench for pb_debouncer with SIMULATE=1
module tb_pb_debouncer;

`ifdef PB_DEBOUNCER_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  pbtn_in;
    logic [15:0] switch_in;
    logic [5:0]  pbtn_db;
    logic [15:0] swtch_db;
    logic [5:0]  pbtn_rise;
    logic        tick;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    pb_debouncer #(.SIMULATE(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .pbtn_in   (pbtn_in),
        .switch_in (switch_in),
        .pbtn_db   (pbtn_db),
        .swtch_db  (swtch_db),
        .pbtn_rise (pbtn_rise),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic expect_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=%0h expected=queued_entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur(input int sel);
        if (sel < 6) return pbtn_db[sel];
        return swtch_db[sel-6];
    endfunction

    // k = number of posedges until the selected debounced bit reads val, -1 on timeout
    task automatic wait_bit(input int sel, input logic val, output int k, output logic [5:0] racc);
        k    = -1;
        racc = '0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            racc |= pbtn_rise;
            if (cur(sel) === val) begin
                k = n;
                break;
            end
        end
    endtask

    function automatic logic [31:0] all_out();
        return {3'b0, pbtn_db, swtch_db, pbtn_rise, tick};
    endfunction

    initial begin
        int         k;
        int         n;
        logic [5:0] racc;
        logic [15:0] sw_acc;

        // reset held: outputs stay zero while inputs toggle
        reset = 1'b0;
        pbtn_in = 6'b000001;
        switch_in = '0;
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            pbtn_in   = 6'($urandom);
            switch_in = 16'($urandom);
            expect_push($sformatf("reset_hold_%0d", i), 32'd0);
            step();
            @(negedge clk);
            check(all_out());
        end
        pbtn_in = 6'b000001;
        switch_in = '0;
        step();
        step();
        reset = 1'b1;

        k = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (tick === 1'b1) begin
                k = i;
                break;
            end
        end
        expect_push($sformatf("tick_first_k%0d_in_3_4", k), 32'd1);
        check(32'(k >= 3 && k <= 4));
        for (int p = 0; p < 2; p++) begin
            n = -1;
            for (int i = 1; i <= 10; i++) begin
                @(posedge clk);
                @(negedge clk);
                if (tick === 1'b1) begin
                    n = i;
                    break;
                end
            end
            expect_push("tick_period", 32'd4);
            check(32'(n));
        end

        // btn4 press: latency window and one-cycle rise pulse
        step();
        pbtn_in[4] = 1'b1;
        expect_push("btn4_press_latency", 32'd1);
        expect_push("btn4_no_early_rise", 32'd0);
        expect_push("btn4_db", 32'h10);
        expect_push("btn4_rise_same_cycle", 32'd0);
        expect_push("btn4_rise_next", {26'b0, {6{EDGE_EN}} & 6'b010000});
        expect_push("btn4_rise_after", 32'd0);
        wait_bit(4, 1'b1, k, racc);
        check(32'(k >= 19 && k <= 22));
        check(32'(racc));
        check(32'(pbtn_db));
        check(32'(pbtn_rise));
        @(posedge clk);
        @(negedge clk);
        check(32'(pbtn_rise));
        @(posedge clk);
        @(negedge clk);
        check(32'(pbtn_rise));

        // 10-cycle switch glitch is rejected
        step();
        switch_in[7] = 1'b1;
        repeat (10) step();
        switch_in[7] = 1'b0;
        sw_acc = '0;
        racc   = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            sw_acc |= swtch_db;
            racc   |= pbtn_rise;
        end
        expect_push("sw7_glitch_db", 32'd0);
        expect_push("sw7_glitch_rise", 32'd0);
        check(32'(sw_acc));
        check(32'(racc));

        // btn0 active-low press then release
        step();
        pbtn_in[0] = 1'b0;
        expect_push("btn0_press_latency", 32'd1);
        expect_push("btn0_press_db", 32'h11);
        wait_bit(0, 1'b1, k, racc);
        check(32'(k >= 19 && k <= 22));
        check(32'(pbtn_db));
        repeat (3) step();
        pbtn_in[0] = 1'b1;
        expect_push("btn0_release_latency", 32'd1);
        expect_push("btn0_release_no_rise", 32'd0);
        expect_push("btn0_release_db", 32'h10);
        wait_bit(0, 1'b0, k, racc);
        check(32'(k >= 19 && k <= 22));
        check(32'(racc));
        check(32'(pbtn_db));

        // reset mid-count with btn4 still held and accepted
        step();
        switch_in = 16'hA5A5;
        repeat (12) step();
        pbtn_in[2] = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        expect_push("midreset_outputs", 32'd0);
        check(all_out());
        repeat (3) step();
        reset = 1'b1;
        expect_push("post_reset_latency", 32'd1);
        expect_push("post_reset_swtch", 32'hA5A5);
        expect_push("post_reset_pbtn", 32'h14);
        expect_push("post_reset_rise", {26'b0, {6{EDGE_EN}} & 6'b010100});
        wait_bit(6, 1'b1, k, racc);
        check(32'(k >= 19 && k <= 22));
        check(32'(swtch_db));
        check(32'(pbtn_db));
        @(posedge clk);
        @(negedge clk);
        check(32'(pbtn_rise));

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
